lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one decoded memory op into one or two word-aligned
// bus beats and returns the extended load result as a single response pulse.
module lsu_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_w,
  input  logic [3:0]        reg_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  // state  | meaning
  // IDLE   | ready for a new op
  // REQ0   | first beat requested, waiting for gnt
  // WAIT0  | first read beat outstanding
  // REQ1   | second beat (word + 4) requested
  // WAIT1  | second read beat outstanding
  // RESP   | one-cycle response
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]        state;
  logic              st_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              split_q;
  logic              err_q;
  logic [3:0]        be0_q;
  logic [3:0]        be1_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wd_q;
  logic [31:0]       beat0_q;
  logic [31:0]       beat1_q;

  logic              sel_store;
  logic [2:0]        sel_f3;
  logic              sel_legal;
  logic [3:0]        size_mask;
  logic [7:0]        lane_mask;
  logic              sel_split;
  logic              sel_err;
  logic [63:0]       wd_dup;
  logic [31:0]       wd_rot;
  logic [63:0]       ld_cat;
  logic [31:0]       ld_raw;
  logic [31:0]       ld_ext;

  always_comb begin
    sel_store = mem_w[0];
    sel_f3    = mem_w[0] ? mem_w[3:1] : reg_w[3:1];
    sel_legal = 1'b0;
    if (mem_w[0])
      sel_legal = (sel_f3 <= 3'd2);
    else if (reg_w[0])
      sel_legal = (sel_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (sel_f3[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    // upper nibble of the shifted mask is the lane set of the next word
    lane_mask = {4'b0000, size_mask} << addr[1:0];
    sel_split = |lane_mask[7:4];
    sel_err   = !sel_legal || (sel_split && !SPLIT_EN);
    wd_dup    = {wdata, wdata};
    wd_rot    = wd_dup[6'd32 - {1'b0, addr[1:0], 3'b000} +: 32];
  end

  always_comb begin
    ld_cat = {beat1_q, beat0_q};
    ld_raw = ld_cat[{off_q, 3'b000} +: 32];
    case (f3_q)
      3'd0:    ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
      3'd1:    ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
      3'd4:    ld_ext = {24'd0, ld_raw[7:0]};
      3'd5:    ld_ext = {16'd0, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      st_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      be0_q   <= 4'd0;
      be1_q   <= 4'd0;
      waddr_q <= '0;
      wd_q    <= 32'd0;
      beat0_q <= 32'd0;
      beat1_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            st_q    <= sel_store;
            f3_q    <= sel_f3;
            off_q   <= addr[1:0];
            split_q <= sel_split;
            err_q   <= sel_err;
            be0_q   <= lane_mask[3:0];
            be1_q   <= lane_mask[7:4];
            waddr_q <= {addr[ADDR_W-1:2], 2'b00};
            wd_q    <= wd_rot;
            beat0_q <= 32'd0;
            beat1_q <= 32'd0;
            state   <= sel_err ? S_RESP : S_REQ0;
          end
        end
        S_REQ0: begin
          if (bus_gnt) begin
            if (!st_q)
              state <= S_WAIT0;
            else
              state <= split_q ? S_REQ1 : S_RESP;
          end
        end
        S_WAIT0: begin
          if (bus_rvalid) begin
            beat0_q <= bus_rdata;
            state   <= split_q ? S_REQ1 : S_RESP;
          end
        end
        S_REQ1: begin
          if (bus_gnt)
            state <= st_q ? S_RESP : S_WAIT1;
        end
        S_WAIT1: begin
          if (bus_rvalid) begin
            beat1_q <= bus_rdata;
            state   <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    bus_req   = (state == S_REQ0) || (state == S_REQ1);
    bus_we    = bus_req && st_q;
    bus_wdata = bus_req ? wd_q : 32'd0;
    bus_addr  = '0;
    bus_be    = 4'd0;
    if (state == S_REQ0) begin
      bus_addr = waddr_q;
      bus_be   = be0_q;
    end else if (state == S_REQ1) begin
      bus_addr = waddr_q + ADDR_W'(4);
      bus_be   = be1_q;
    end
    rsp_valid = (state == S_RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !st_q) ? ld_ext : 32'd0;
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus random ops checked against a
// byte-level memory model; a second instance covers the no-split variant.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  mem_w;
  logic [3:0]  reg_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        req_valid_ns;
  logic        req_ready_ns;
  logic        bus_req_ns;
  logic        bus_we_ns;
  logic [31:0] bus_addr_ns;
  logic [3:0]  bus_be_ns;
  logic [31:0] bus_wdata_ns;
  logic        bus_gnt_ns;
  logic        rsp_valid_ns;
  logic [31:0] rsp_rdata_ns;
  logic        rsp_err_ns;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  logic [31:0] last_addr [0:1];
  logic [3:0]  last_be   [0:1];
  logic [31:0] last_wd   [0:1];
  logic        last_we   [0:1];
  int          last_nb;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_w(mem_w), .reg_w(reg_w), .addr(addr), .wdata(wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  lsu_mem_ctrl #(.ADDR_W(32), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
    .mem_w(mem_w), .reg_w(reg_w), .addr(addr), .wdata(wdata),
    .bus_req(bus_req_ns), .bus_we(bus_we_ns), .bus_addr(bus_addr_ns), .bus_be(bus_be_ns),
    .bus_wdata(bus_wdata_ns), .bus_gnt(bus_gnt_ns), .bus_rvalid(1'b0),
    .bus_rdata(32'd0), .rsp_valid(rsp_valid_ns), .rsp_rdata(rsp_rdata_ns),
    .rsp_err(rsp_err_ns)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: works byte by byte on the access footprint.
  task automatic model_op(input logic [3:0] mw, input logic [3:0] rw, input logic [31:0] a,
                          input logic [31:0] wd, input bit split_en,
                          output bit err, output bit st, output int nb,
                          output logic [3:0] be0, output logic [3:0] be1,
                          output logic [31:0] wrot, output logic [31:0] rdat);
    logic [2:0]  f3;
    bit          legal;
    int          size;
    int          o;
    logic [31:0] ba;
    logic [31:0] w;
    logic [31:0] v;
    st = mw[0];
    f3 = mw[0] ? mw[3:1] : rw[3:1];
    if (mw[0])      legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else if (rw[0]) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    else            legal = 1'b0;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    o = int'(a[1:0]);
    be0 = 4'd0;
    be1 = 4'd0;
    for (int i = 0; i < size; i++) begin
      if (o + i < 4) be0[o + i] = 1'b1;
      else           be1[o + i - 4] = 1'b1;
    end
    err = !legal || ((o + size > 4) && !split_en);
    nb  = err ? 0 : ((o + size > 4) ? 2 : 1);
    for (int l = 0; l < 4; l++) begin
      int src;
      src = (l - o) & 3;
      wrot[8*l +: 8] = wd[8*src +: 8];
    end
    rdat = 32'd0;
    if (!err && !st) begin
      v = 32'd0;
      for (int i = 0; i < size; i++) begin
        int k;
        ba = a + 32'(i);
        w  = mem[ba[9:2]];
        k  = int'(ba[1:0]);
        v[8*i +: 8] = w[8*k +: 8];
      end
      if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
      rdat = v;
    end
  endtask

  // Called at posedge+1 in an idle cycle; returns at posedge+1 of the next idle cycle.
  task automatic do_op(input logic [3:0] mw, input logic [3:0] rw, input logic [31:0] a,
                       input logic [31:0] wd, input bit fast,
                       output logic [31:0] got_rdata, output logic got_err, output int got_lat);
    bit          e_err, e_st;
    int          e_nb;
    logic [3:0]  e_be0, e_be1;
    logic [31:0] e_wrot, e_rdat;
    bit          pending = 0;
    bit          done = 0;
    int          rv_wait = 0;
    int          cyc;
    logic [7:0]  rd_word = 8'd0;
    model_op(mw, rw, a, wd, 1'b1, e_err, e_st, e_nb, e_be0, e_be1, e_wrot, e_rdat);
    check_val("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    mem_w = mw; reg_w = rw; addr = a; wdata = wd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_w = 4'($urandom); reg_w = 4'($urandom); addr = $urandom; wdata = $urandom;
    last_nb = 0;
    got_rdata = 32'd0; got_err = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (cyc == 1) check_val("ready_busy", {31'd0, req_ready}, 32'd0);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (rsp_valid) begin
        done = 1;
        got_rdata = rsp_rdata;
        got_err = rsp_err;
      end else begin
        if (!pending && !fast && $urandom_range(0, 3) == 0) bus_rvalid = 1'b1;
        if (pending) begin
          rv_wait--;
          if (rv_wait == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata = mem[rd_word];
            pending = 0;
          end
        end else if (bus_req && (fast || $urandom_range(0, 1) == 1)) begin
          bus_gnt = 1'b1;
          if (last_nb < 2) begin
            last_addr[last_nb] = bus_addr; last_be[last_nb] = bus_be;
            last_wd[last_nb] = bus_wdata;  last_we[last_nb] = bus_we;
          end
          if (last_nb >= e_nb) begin
            check_val("extra_beat", 32'(last_nb + 1), 32'(e_nb));
          end else begin
            check_val("beat_addr", bus_addr, {a[31:2], 2'b00} + 32'(4 * last_nb));
            check_val("beat_be", {28'd0, bus_be}, {28'd0, (last_nb == 0) ? e_be0 : e_be1});
            check_val("beat_we", {31'd0, bus_we}, {31'd0, e_st});
            if (e_st) check_val("beat_wdata", bus_wdata, e_wrot);
          end
          if (bus_we) begin
            for (int b = 0; b < 4; b++)
              if (bus_be[b]) mem[bus_addr[9:2]][8*b +: 8] = bus_wdata[8*b +: 8];
          end else begin
            pending = 1;
            rd_word = bus_addr[9:2];
            rv_wait = fast ? 1 : $urandom_range(1, 3);
          end
          last_nb++;
        end
      end
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    got_lat = cyc;
    if (!done) check_val("rsp_timeout", 32'd0, 32'd1);
    check_val("rsp_err", {31'd0, got_err}, {31'd0, e_err});
    check_val("rsp_rdata", got_rdata, e_rdat);
    check_val("beat_count", 32'(last_nb), 32'(e_nb));
    if (fast)
      check_val("latency", 32'(cyc), e_err ? 32'd1 : 32'(1 + e_nb * (e_st ? 1 : 2)));
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    check_val("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  // Store-only driver for the SPLIT_EN=0 instance.
  task automatic ns_store(input logic [3:0] mw, input logic [31:0] a, input logic [31:0] wd,
                          output logic got_err, output int got_nb, output int got_lat);
    bit done = 0;
    int cyc = 1;
    bit          e_err, e_st;
    int          e_nb;
    logic [3:0]  e_be0, e_be1;
    logic [31:0] e_wrot, e_rdat;
    model_op(mw, 4'd0, a, wd, 1'b0, e_err, e_st, e_nb, e_be0, e_be1, e_wrot, e_rdat);
    req_valid_ns = 1'b1;
    mem_w = mw; reg_w = 4'd0; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid_ns = 1'b0;
    got_nb = 0; got_err = 1'b0;
    while (!done && cyc < 20) begin
      bus_gnt_ns = 1'b0;
      if (rsp_valid_ns) begin
        done = 1;
        got_err = rsp_err_ns;
        check_val("ns_rdata", rsp_rdata_ns, 32'd0);
      end else begin
        if (bus_req_ns) begin
          bus_gnt_ns = 1'b1;
          check_val("ns_addr", bus_addr_ns, {a[31:2], 2'b00});
          check_val("ns_be", {28'd0, bus_be_ns}, {28'd0, e_be0});
          check_val("ns_we", {31'd0, bus_we_ns}, 32'd1);
          check_val("ns_wdata", bus_wdata_ns, e_wrot);
          got_nb++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    got_lat = cyc;
    if (!done) check_val("ns_timeout", 32'd0, 32'd1);
    bus_gnt_ns = 1'b0;
    @(posedge clk); #1;
    check_val("ns_ready", {31'd0, req_ready_ns}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;
    int          r_nb;
    bit          stray;
    rst = 1'b1;
    req_valid = 1'b0; req_valid_ns = 1'b0;
    mem_w = 4'd0; reg_w = 4'd0; addr = 32'd0; wdata = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_gnt_ns = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_val("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check_val("rst_bus_addr", bus_addr, 32'd0);
    check_val("rst_bus_wdata", bus_wdata, 32'd0);
    check_val("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // LW 0x100
    mem[8'h40] = 32'hDEADBEEF;
    do_op(4'b0000, 4'b0101, 32'h100, 32'd0, 1'b1, r_data, r_err, r_lat);
    check_val("lw_data", r_data, 32'hDEADBEEF);
    check_val("lw_lat", 32'(r_lat), 32'd3);
    check_val("lw_addr", last_addr[0], 32'h100);
    check_val("lw_be", {28'd0, last_be[0]}, 32'hF);

    // LH / LHU 0x103, split
    mem[8'h40] = 32'h80AABBCC;
    mem[8'h41] = 32'h33445512;
    do_op(4'b0000, 4'b0011, 32'h103, 32'd0, 1'b1, r_data, r_err, r_lat);
    check_val("lh_data", r_data, 32'h00001280);
    check_val("lh_nb", 32'(last_nb), 32'd2);
    check_val("lh_b0", {last_addr[0][27:0], last_be[0]}, {28'h0000100, 4'b1000});
    check_val("lh_b1", {last_addr[1][27:0], last_be[1]}, {28'h0000104, 4'b0001});
    do_op(4'b0000, 4'b1011, 32'h103, 32'd0, 1'b0, r_data, r_err, r_lat);
    check_val("lhu_data", r_data, 32'h00001280);

    // LB / LBU 0x101
    mem[8'h40] = 32'h0000F000;
    do_op(4'b0000, 4'b0001, 32'h101, 32'd0, 1'b1, r_data, r_err, r_lat);
    check_val("lb_data", r_data, 32'hFFFFFFF0);
    do_op(4'b0000, 4'b1001, 32'h101, 32'd0, 1'b1, r_data, r_err, r_lat);
    check_val("lbu_data", r_data, 32'h000000F0);

    // SB 0x203
    do_op(4'b0001, 4'b0000, 32'h203, 32'h000000A5, 1'b1, r_data, r_err, r_lat);
    check_val("sb_nb", 32'(last_nb), 32'd1);
    check_val("sb_addr", last_addr[0], 32'h200);
    check_val("sb_be", {28'd0, last_be[0]}, 32'h8);
    check_val("sb_lane", {24'd0, last_wd[0][31:24]}, 32'hA5);
    check_val("sb_we", {31'd0, last_we[0]}, 32'd1);
    check_val("sb_rdata", r_data, 32'd0);
    check_val("sb_lat", 32'(r_lat), 32'd2);

    // SW 0x102, split
    do_op(4'b0101, 4'b0000, 32'h102, 32'h11223344, 1'b1, r_data, r_err, r_lat);
    check_val("sw_b0", {last_addr[0][27:0], last_be[0]}, {28'h0000100, 4'b1100});
    check_val("sw_b1", {last_addr[1][27:0], last_be[1]}, {28'h0000104, 4'b0011});
    check_val("sw_wd0", last_wd[0], 32'h33441122);
    check_val("sw_wd1", last_wd[1], 32'h33441122);

    // store with funct3 = 4
    do_op(4'b1001, 4'b0000, 32'h100, 32'h1, 1'b1, r_data, r_err, r_lat);
    check_val("st4_err", {31'd0, r_err}, 32'd1);
    check_val("st4_lat", 32'(r_lat), 32'd1);
    check_val("st4_nb", 32'(last_nb), 32'd0);

    // reset while WAIT0, rvalid arrives afterwards
    req_valid = 1'b1; mem_w = 4'b0000; reg_w = 4'b0101; addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("rst_mid_req", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    check_val("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || !req_ready) stray = 1;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
    end
    check_val("rst_mid_no_rsp", {31'd0, stray}, 32'd0);

    // SPLIT_EN = 0 instance
    ns_store(4'b0101, 32'h102, 32'h11223344, r_err, r_nb, r_lat);
    check_val("ns_sw_split_err", {31'd0, r_err}, 32'd1);
    check_val("ns_sw_split_nb", 32'(r_nb), 32'd0);
    check_val("ns_sw_split_lat", 32'(r_lat), 32'd1);
    ns_store(4'b0101, 32'h100, 32'h55667788, r_err, r_nb, r_lat);
    check_val("ns_sw_ok_err", {31'd0, r_err}, 32'd0);
    check_val("ns_sw_ok_nb", 32'(r_nb), 32'd1);
    check_val("ns_sw_ok_lat", 32'(r_lat), 32'd2);
    ns_store(4'b0011, 32'h103, 32'hABCD, r_err, r_nb, r_lat);
    check_val("ns_sh3_err", {31'd0, r_err}, 32'd1);
    ns_store(4'b0011, 32'h102, 32'hABCD, r_err, r_nb, r_lat);
    check_val("ns_sh2_err", {31'd0, r_err}, 32'd0);

    // random ops
    for (int n = 0; n < 250; n++) begin
      logic [3:0]  mw, rw;
      logic [2:0]  f3;
      int          r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        f3 = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
        mw = {f3, 1'b1};
        rw = 4'($urandom);
      end else if (r < 9) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        mw = {3'($urandom), 1'b0};
        rw = {f3, 1'b1};
      end else begin
        mw = 4'($urandom);
        rw = 4'($urandom);
      end
      do_op(mw, rw, 32'h100 + 32'($urandom_range(0, 127)), $urandom,
            ($urandom_range(0, 3) == 0), r_data, r_err, r_lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
